// File: rtl/register_file.sv
// 32x32 register file with two registered read ports, write-through bypass,
// and a busy scoreboard tracking in-flight destination registers.
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] wb_data_in,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic        issue_en,
    input  logic [4:0]  issue_rd,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        rs_busy,
    output logic        rt_busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_REGS = 32;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   rs_data_q, rs_data_d;
    logic [DATA_W-1:0]   rt_data_q, rt_data_d;
    logic                rs_busy_q, rs_busy_d;
    logic                rt_busy_q, rt_busy_d;

    logic                wr_en;
    logic                iss_en;
    logic [NUM_REGS-1:0] wr_mask;
    logic [NUM_REGS-1:0] iss_mask;
    logic [NUM_REGS-1:0] busy_cleared;

    // Register array update, bypassed reads, and scoreboard next state.
    always_comb begin
        wr_en        = reg_write_in && (rd_in != 5'd0);
        iss_en       = issue_en && (issue_rd != 5'd0);
        wr_mask      = wr_en  ? (NUM_REGS'(1) << rd_in)    : '0;
        iss_mask     = iss_en ? (NUM_REGS'(1) << issue_rd) : '0;

        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd_in] = wb_data_in;
        end

        // Reported busy sees the same-edge clear but not the same-edge set.
        busy_cleared = busy_q & ~wr_mask;
        busy_d       = busy_cleared | iss_mask;
        busy_d[0]    = 1'b0;

        if (rs_addr == 5'd0) begin
            rs_data_d = '0;
        end else if (wr_en && (rd_in == rs_addr)) begin
            rs_data_d = wb_data_in;
        end else begin
            rs_data_d = regs_q[rs_addr];
        end

        if (rt_addr == 5'd0) begin
            rt_data_d = '0;
        end else if (wr_en && (rd_in == rt_addr)) begin
            rt_data_d = wb_data_in;
        end else begin
            rt_data_d = regs_q[rt_addr];
        end

        rs_busy_d = busy_cleared[rs_addr];
        rt_busy_d = busy_cleared[rt_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            rs_busy_q <= 1'b0;
            rt_busy_q <= 1'b0;
        end else begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            regs_q[0] <= '0;
            busy_q    <= busy_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rs_busy_q <= rs_busy_d;
            rt_busy_q <= rt_busy_d;
        end
    end

    assign rs_data = rs_data_q;
    assign rt_data = rt_data_q;
    assign rs_busy = rs_busy_q;
    assign rt_busy = rt_busy_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus reset/fill sequence,
// expected outputs queued at drive time and checked after the sampling edge.
module tb_register_file;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ie;
        logic [4:0]  ird;
        logic [31:0] ers;
        logic [31:0] ert;
        logic        ersb;
        logic        ertb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write_in = 1'b0;
    logic [4:0]  rd_in = '0;
    logic [31:0] wb_data_in = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rs_busy;
    logic        rt_busy;

    int n_checks = 0;
    int n_fail = 0;
    vec_t sb [$];
    vec_t tbl [19];

    register_file dut (
        .clk          (clk),
        .reset        (reset),
        .reg_write_in (reg_write_in),
        .rd_in        (rd_in),
        .wb_data_in   (wb_data_in),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic we, logic [4:0] rd, logic [31:0] wd,
                                logic [4:0] rs, logic [4:0] rt, logic ie, logic [4:0] ird,
                                logic [31:0] ers, logic [31:0] ert, logic ersb, logic ertb);
        vec_t v;
        v.rst = rst; v.we = we; v.rd = rd; v.wd = wd; v.rs = rs; v.rt = rt;
        v.ie = ie; v.ird = ird; v.ers = ers; v.ert = ert; v.ersb = ersb; v.ertb = ertb;
        return v;
    endfunction

    task automatic check32(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // Drive one edge worth of inputs, queue the expectation, check after the edge.
    task automatic apply(vec_t v, int idx);
        vec_t e;
        @(negedge clk);
        reset        = v.rst;
        reg_write_in = v.we;
        rd_in        = v.rd;
        wb_data_in   = v.wd;
        rs_addr      = v.rs;
        rt_addr      = v.rt;
        issue_en     = v.ie;
        issue_rd     = v.ird;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check32("rs_data", idx, rs_data, e.ers);
        check32("rt_data", idx, rt_data, e.ert);
        check32("rs_busy", idx, 32'(rs_busy), 32'(e.ersb));
        check32("rt_busy", idx, 32'(rt_busy), 32'(e.ertb));
    endtask

    initial begin
        //            rst we rd  wd            rs  rt  ie ird  ers           ert           rsb  rtb
        tbl[0]  = mk(1, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0);
        tbl[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0,  0,  0, 0,  32'h0,        32'h0,        0, 0);
        tbl[2]  = mk(0, 0, 0,  32'h0,        5,  5,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(0, 1, 7,  32'h1,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0);
        tbl[4]  = mk(0, 1, 7,  32'h12345678, 7,  5,  0, 0,  32'h12345678, 32'hDEADBEEF, 0, 0);
        tbl[5]  = mk(0, 1, 0,  32'hFFFFFFFF, 0,  7,  0, 0,  32'h0,        32'h12345678, 0, 0);
        tbl[6]  = mk(0, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0);
        tbl[7]  = mk(0, 0, 0,  32'h0,        3,  3,  1, 3,  32'h0,        32'h0,        0, 0);
        tbl[8]  = mk(0, 0, 0,  32'h0,        5,  3,  0, 0,  32'hDEADBEEF, 32'h0,        0, 1);
        tbl[9]  = mk(0, 1, 3,  32'hAAAA5555, 3,  3,  0, 0,  32'hAAAA5555, 32'hAAAA5555, 0, 0);
        tbl[10] = mk(0, 0, 0,  32'h0,        3,  3,  0, 0,  32'hAAAA5555, 32'hAAAA5555, 0, 0);
        tbl[11] = mk(0, 1, 3,  32'h0BADF00D, 3,  0,  1, 3,  32'h0BADF00D, 32'h0,        0, 0);
        tbl[12] = mk(0, 0, 0,  32'h0,        3,  3,  0, 0,  32'h0BADF00D, 32'h0BADF00D, 1, 1);
        tbl[13] = mk(0, 0, 0,  32'h0,        0,  0,  1, 0,  32'h0,        32'h0,        0, 0);
        tbl[14] = mk(0, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0);
        tbl[15] = mk(0, 1, 3,  32'h11,       3,  10, 1, 10, 32'h11,       32'h0,        0, 0);
        tbl[16] = mk(0, 0, 0,  32'h0,        3,  10, 0, 0,  32'h11,       32'h0,        0, 1);
        tbl[17] = mk(0, 1, 10, 32'h22,       10, 3,  0, 0,  32'h22,       32'h11,       0, 0);
        tbl[18] = mk(0, 1, 20, 32'h33,       20, 10, 0, 0,  32'h33,       32'h22,       0, 0);

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i], i);
        end

        // Fill r1..r31 with nonzero values; mark r4 busy on the last fill edge.
        for (int i = 1; i < 32; i++) begin
            apply(mk(0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 0, (i == 31), 5'd4,
                     32'h0, 32'h0, 0, 0), 100 + i);
        end
        apply(mk(0, 0, 0, 32'h0, 4, 31, 0, 0, 32'h04040404, 32'h1F1F1F1F, 1, 0), 140);

        // Reset edge wins over a same-edge write to r9 and issue of r12.
        apply(mk(1, 1, 9, 32'hCAFEF00D, 9, 4, 1, 12, 32'h0, 32'h0, 0, 0), 150);
        for (int i = 0; i < 32; i++) begin
            apply(mk(0, 0, 0, 32'h0, 5'(i), 5'(31 - i), 0, 0, 32'h0, 32'h0, 0, 0), 200 + i);
        end

        // No extra latency after reset: bypassed write then plain read.
        apply(mk(0, 1, 9, 32'h99, 9, 9, 0, 0, 32'h99, 32'h99, 0, 0), 300);
        apply(mk(0, 0, 0, 32'h0,  9, 4, 0, 0, 32'h99, 32'h0,  0, 0), 301);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
